multicycle_control_fsm: RTL and testbench

Multi-cycle main control unit for the RISC-V subset core. It latches the fetched instruction and sequences each instruction through fetch, decode, execute, memory and writeback states. In every state it drives the datapath enables and produces the ALUOp and Funct pair consumed by the ALU control decoder. It sits between instruction memory and the datapath, upstream of ALU_Control.

---
 rtl/multicycle_control_fsm.sv | 129 ++++++++++++
 tb/tb_multicycle_control_fsm.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle main control for the RISC-V subset core: latches the fetched word and
// sequences FETCH/DECODE/EXEC/MEM/WB, driving datapath enables and the ALUOp/Funct pair.
module multicycle_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        instr_valid,
  input  logic        mem_ready,
  output logic [1:0]  ALUOp,
  output logic [3:0]  Funct,
  output logic        IRWrite,
  output logic        ALUSrc,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        PCWrite,
  output logic        illegal,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ir_q;

  logic is_r, is_i, is_ld, is_sd, is_br, legal;
  logic [1:0] aluop_ir;
  logic [3:0] funct_ir;

  always_comb begin
    is_r  = (ir_q[6:0] == 7'b0110011);
    is_i  = (ir_q[6:0] == 7'b0010011);
    is_ld = (ir_q[6:0] == 7'b0000011);
    is_sd = (ir_q[6:0] == 7'b0100011);
    is_br = (ir_q[6:0] == 7'b1100011);
    legal = is_r | is_i | is_ld | is_sd | is_br;
    aluop_ir = is_r ? 2'b10 : (is_br ? 2'b01 : 2'b00);
    funct_ir = {ir_q[30], ir_q[14:12]};
  end

  // Fields not consumed by this decoder; the full word is still latched.
  logic unused_ir;
  assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && instr_valid) ir_q <= instruction;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (instr_valid) state_d = S_DECODE;
      S_DECODE: state_d = legal ? S_EXEC : S_FETCH;
      S_EXEC: begin
        if (is_br)                state_d = S_FETCH;
        else if (is_ld || is_sd)  state_d = S_MEM;
        else                      state_d = S_WB;
      end
      S_MEM:    if (mem_ready) state_d = is_ld ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs are forced low while reset is held so an aborted instruction
  // produces no further enables or PC update.
  always_comb begin
    ALUOp    = 2'b00;
    Funct    = 4'b0000;
    IRWrite  = 1'b0;
    ALUSrc   = 1'b0;
    Branch   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    PCWrite  = 1'b0;
    illegal  = 1'b0;
    busy     = 1'b0;
    if (!reset) begin
      busy = (state_q != S_FETCH);
      if (state_q != S_FETCH) begin
        ALUOp = aluop_ir;
        Funct = funct_ir;
      end
      case (state_q)
        S_FETCH: IRWrite = instr_valid;
        S_DECODE: begin
          illegal = ~legal;
          PCWrite = ~legal;
        end
        S_EXEC: begin
          ALUSrc  = is_i | is_ld | is_sd;
          Branch  = is_br;
          PCWrite = is_br;
        end
        S_MEM: begin
          // Address operand kept selected while the memory request is outstanding.
          ALUOp    = 2'b00;
          ALUSrc   = 1'b1;
          MemRead  = is_ld;
          MemWrite = is_sd;
          PCWrite  = is_sd & mem_ready;
        end
        S_WB: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          MemtoReg = is_ld;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench: a per-instruction trace model queues expected outputs per cycle;
// a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic        instr_valid = 1'b0;
  logic        mem_ready = 1'b0;
  logic [1:0]  ALUOp;
  logic [3:0]  Funct;
  logic        IRWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg;
  logic        RegWrite, PCWrite, illegal, busy;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .ALUOp(ALUOp), .Funct(Funct), .IRWrite(IRWrite),
    .ALUSrc(ALUSrc), .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .PCWrite(PCWrite), .illegal(illegal),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // {ALUOp, Funct, IRWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, RegWrite, PCWrite, illegal, busy}
  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic logic [15:0] mk(logic [1:0] aop, logic [3:0] f, logic irw, logic src,
                                     logic br, logic mrd, logic mwr, logic m2r, logic rw,
                                     logic pcw, logic ill, logic bsy);
    return {aop, f, irw, src, br, mrd, mwr, m2r, rw, pcw, ill, bsy};
  endfunction

  always @(negedge clk) begin
    logic [15:0] act, e;
    cyc++;
    act = {ALUOp, Funct, IRWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg,
           RegWrite, PCWrite, illegal, busy};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs cyc %0d got %b want %b (aop,funct,irw,src,br,mrd,mwr,m2r,rw,pcw,ill,busy)",
                 cyc, act, e);
      end
    end
  end

  task automatic step(logic rs, logic iv, logic mr, logic [31:0] ins, logic [15:0] e);
    @(posedge clk);
    #1;
    reset = rs; instr_valid = iv; mem_ready = mr; instruction = ins;
    exp_q.push_back(e);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic idle();
    step(1'b0, 1'b0, rb(), $urandom, '0);
  endtask

  // Whole-instruction model: walks the architectural phases and emits one expected
  // output word per cycle. abort_at >= 0 asserts reset in that MEM wait cycle.
  task automatic run(logic [31:0] ins, int waits, int abort_at = -1);
    logic [6:0] opc;
    logic r, ii, ld, sd, br, ill;
    logic [1:0] aop;
    logic [3:0] f;
    opc = ins[6:0];
    r  = (opc == 7'h33); ii = (opc == 7'h13); ld = (opc == 7'h03);
    sd = (opc == 7'h23); br = (opc == 7'h63);
    ill = !(r || ii || ld || sd || br);
    aop = r ? 2'b10 : (br ? 2'b01 : 2'b00);
    f = {ins[30], ins[14:12]};
    step(1'b0, 1'b1, rb(), ins, mk(2'b00, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1'b0, rb(), rb(), $urandom, mk(aop, f, 0, 0, 0, 0, 0, 0, 0, ill, ill, 1));
    if (ill) return;
    step(1'b0, rb(), rb(), $urandom, mk(aop, f, 0, ii | ld | sd, br, 0, 0, 0, 0, br, 0, 1));
    if (br) return;
    if (ld || sd) begin
      for (int i = 0; i <= waits; i++) begin
        if (i == abort_at) begin
          step(1'b1, rb(), rb(), $urandom, '0);
          step(1'b0, 1'b0, rb(), $urandom, '0);
          return;
        end
        step(1'b0, rb(), (i == waits), $urandom,
             mk(2'b00, f, 0, 1, 0, ld, sd, 0, 0, sd && (i == waits), 0, 1));
      end
      if (sd) return;
    end
    step(1'b0, rb(), rb(), $urandom, mk(aop, f, 0, 0, 0, 0, 0, ld, 1, 1, 0, 1));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0] opc;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: opc = 7'h33;
      1: opc = 7'h13;
      2: opc = 7'h03;
      3: opc = 7'h23;
      4: opc = 7'h63;
      default: begin
        opc = 7'($urandom);
        if (opc == 7'h33 || opc == 7'h13 || opc == 7'h03 || opc == 7'h23 || opc == 7'h63)
          opc = 7'h7F;
      end
    endcase
    return {w[31:7], opc};
  endfunction

  initial begin
    int guard;
    // Reset held: everything low, including busy and IRWrite despite instr_valid.
    step(1'b1, 1'b1, 1'b1, 32'h003100B3, '0);
    step(1'b1, 1'b0, 1'b1, 32'h0, '0);
    idle();
    run(32'h003100B3, 0);          // add
    run(32'h403100B3, 0);          // sub
    run(32'h00833283, 3);          // ld with three wait cycles
    run(32'h0020C463, 0);          // blt
    run(32'h00309093, 0);          // slli
    run(32'h0000007F, 0);          // illegal opcode
    idle();
    run(32'h00533423, 3, 2);       // sd aborted by reset while waiting
    run(32'h003100B3, 0);
    run(32'h00533423, 0);          // sd, ready on MEM entry
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle();
      run(rand_instr(), $urandom_range(0, 3));
    end
    idle();
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
